// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: synchronous-read word store with a program-load port,
// a single in-flight read stage and a 2-entry in-order response buffer.
module instr_fetch_mem #(
    parameter int    DATA_W     = 32,
    parameter int    DEPTH_LOG2 = 13,
    parameter int    BYTE_ADDR  = 0,
    parameter string INIT_FILE  = "",
    localparam int   OFF_W      = (BYTE_ADDR != 0) ? $clog2(DATA_W / 8) : 0,
    localparam int   PC_W       = DEPTH_LOG2 + OFF_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PC_W-1:0]       req_pc,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_instr,
    output logic [PC_W-1:0]       rsp_pc,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  flush
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = 1 + PC_W + DATA_W;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     rd_data_q;
    logic                  inflight_q;
    logic [PC_W-1:0]       inflight_pc_q;
    logic                  inflight_err_q;
    logic [1:0]            cnt_q, cnt_d;
    logic [ENT_W-1:0]      ent0_q, ent0_d;
    logic [ENT_W-1:0]      ent1_q, ent1_d;
    logic [ENT_W-1:0]      new_ent;
    logic [1:0]            occ;
    logic                  pop;
    logic                  accept;
    logic                  misaligned;
    logic [DEPTH_LOG2-1:0] word_idx;

    generate
        if (OFF_W > 0) begin : g_byte
            assign misaligned = |req_pc[OFF_W-1:0];
        end else begin : g_word
            assign misaligned = 1'b0;
        end
    endgenerate

    assign word_idx  = req_pc[PC_W-1:OFF_W];
    assign rsp_valid = (cnt_q != 2'd0);
    assign {rsp_err, rsp_pc, rsp_instr} = ent0_q;
    assign pop       = rsp_valid & rsp_ready;
    assign occ       = cnt_q + {1'b0, inflight_q};
    assign req_ready = rst_n & ~ld_en & ~flush & ((occ < 2'd2) | ((occ == 2'd2) & pop));
    assign accept    = req_valid & req_ready;
    // Misaligned fetches skip the array and complete with a zero word.
    assign new_ent   = {inflight_err_q, inflight_pc_q, inflight_err_q ? {DATA_W{1'b0}} : rd_data_q};

    always_ff @(posedge clk) begin
        if (ld_en && rst_n) mem[ld_addr] <= ld_data;
        if (accept && !misaligned) rd_data_q <= mem[word_idx];
    end

    // Occupancy is capped at 2, so an in-flight completion never finds the buffer full.
    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            case ({pop, inflight_q})
                2'b11: ent0_d = new_ent;
                2'b10: begin
                    ent0_d = ent1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd0) ent0_d = new_ent;
                    else               ent1_d = new_ent;
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            ent0_q         <= '0;
            ent1_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
            inflight_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            inflight_q <= accept;
            if (accept) begin
                inflight_pc_q  <= req_pc;
                inflight_err_q <= misaligned;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed table, hand sequences and random traffic
// checked against a queue-based response model.
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en, flush;
    logic [12:0] req_pc, rsp_pc, ld_addr;
    logic [31:0] rsp_instr, ld_data;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_ld_en, b_flush;
    logic [14:0] b_req_pc, b_rsp_pc;
    logic [12:0] b_ld_addr;
    logic [31:0] b_rsp_instr, b_ld_data;

    instr_fetch_mem #(.DATA_W(32), .DEPTH_LOG2(13), .BYTE_ADDR(0), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_pc(rsp_pc), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .flush(flush)
    );

    instr_fetch_mem #(.DATA_W(32), .DEPTH_LOG2(13), .BYTE_ADDR(1), .INIT_FILE("")) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pc(b_req_pc),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr),
        .rsp_pc(b_rsp_pc), .rsp_err(b_rsp_err),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .flush(b_flush)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [12:0] pc;
        logic [31:0] instr;
        int          vis;
    } ent_t;
    ent_t        q[$];
    logic [31:0] mem_m [16];

    typedef struct {
        logic        rv;
        logic [12:0] pc;
        logic        rr;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [12:0] e_pc;
    } vec_t;
    vec_t tbl [15];

    function automatic logic [31:0] val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare DUT against the model, then advance the model at the edge.
    task automatic cycle();
        logic ev, pop, er, acc;
        int   occ;
        ent_t e;
        #1;
        occ = q.size();
        ev  = rst_n && (occ > 0) && (q[0].vis <= cyc);
        pop = ev && rsp_ready;
        er  = rst_n && !ld_en && !flush && ((occ < 2) || (occ == 2 && pop));
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev) begin
            chk("rsp_instr", 64'(rsp_instr), 64'(q[0].instr));
            chk("rsp_pc", 64'(rsp_pc), 64'(q[0].pc));
            chk("rsp_err", 64'(rsp_err), 64'd0);
        end else if (!rst_n) begin
            chk("rst_instr", 64'(rsp_instr), 64'd0);
            chk("rst_pc", 64'(rsp_pc), 64'd0);
            chk("rst_err", 64'(rsp_err), 64'd0);
        end
        acc = req_valid && er;
        @(posedge clk);
        cyc++;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.pc    = req_pc;
                e.instr = mem_m[req_pc[3:0]];
                e.vis   = cyc + 1;
                q.push_back(e);
            end
        end
        if (ld_en && rst_n) mem_m[ld_addr[3:0]] = ld_data;
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; flush = 1'b0;
        b_req_valid = 1'b0; b_req_pc = '0; b_rsp_ready = 1'b1;
        b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0; b_flush = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 13'd0, 1'b1, 1'b1, 1'b0, 32'd0,  13'd0};
        tbl[1]  = '{1'b1, 13'd1, 1'b1, 1'b1, 1'b0, 32'd0,  13'd0};
        tbl[2]  = '{1'b1, 13'd2, 1'b1, 1'b1, 1'b1, val(0), 13'd0};
        tbl[3]  = '{1'b1, 13'd3, 1'b1, 1'b1, 1'b1, val(1), 13'd1};
        tbl[4]  = '{1'b0, 13'd0, 1'b1, 1'b1, 1'b1, val(2), 13'd2};
        tbl[5]  = '{1'b0, 13'd0, 1'b1, 1'b1, 1'b1, val(3), 13'd3};
        tbl[6]  = '{1'b0, 13'd0, 1'b1, 1'b1, 1'b0, 32'd0,  13'd0};
        tbl[7]  = '{1'b1, 13'd0, 1'b0, 1'b1, 1'b0, 32'd0,  13'd0};
        tbl[8]  = '{1'b1, 13'd1, 1'b0, 1'b1, 1'b0, 32'd0,  13'd0};
        tbl[9]  = '{1'b1, 13'd2, 1'b0, 1'b0, 1'b1, val(0), 13'd0};
        tbl[10] = '{1'b1, 13'd2, 1'b0, 1'b0, 1'b1, val(0), 13'd0};
        tbl[11] = '{1'b1, 13'd2, 1'b1, 1'b1, 1'b1, val(0), 13'd0};
        tbl[12] = '{1'b0, 13'd0, 1'b1, 1'b1, 1'b1, val(1), 13'd1};
        tbl[13] = '{1'b0, 13'd0, 1'b1, 1'b1, 1'b1, val(2), 13'd2};
        tbl[14] = '{1'b0, 13'd0, 1'b1, 1'b1, 1'b0, 32'd0,  13'd0};

        idle();
        rst_n = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1 chk("ready_after_reset", 64'(req_ready), 64'd1);
        cycle();

        for (int i = 0; i < 16; i++) begin
            ld_en = 1'b1; ld_addr = 13'(i); ld_data = val(i);
            b_ld_en = 1'b1; b_ld_addr = 13'(i); b_ld_data = val(i);
            cycle();
        end
        idle();
        cycle();

        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].rv; req_pc = tbl[i].pc; rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 64'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_instr", i), 64'(rsp_instr), 64'(tbl[i].e_instr));
                chk($sformatf("tbl%0d_pc", i), 64'(rsp_pc), 64'(tbl[i].e_pc));
            end
            cycle();
        end

        idle();
        ld_en = 1'b1; ld_addr = 13'd5; ld_data = 32'hDEAD_BEEF; req_valid = 1'b1; req_pc = 13'd5;
        #1 chk("load_ready", 64'(req_ready), 64'd0);
        cycle();
        ld_en = 1'b0;
        cycle();
        req_valid = 1'b0;
        cycle();
        #1 chk("load_fetch_instr", 64'(rsp_instr), 64'hDEAD_BEEF);
        cycle();

        req_valid = 1'b1; req_pc = 13'd6;
        cycle();
        req_valid = 1'b0; ld_en = 1'b1; ld_addr = 13'd6; ld_data = 32'hCAFE_F00D;
        cycle();
        ld_en = 1'b0;
        #1 chk("inflight_old_value", 64'(rsp_instr), 64'(val(6)));
        cycle();
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        cycle();
        #1 chk("reload_new_value", 64'(rsp_instr), 64'hCAFE_F00D);
        cycle();

        idle();
        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 13'd7;
        cycle();
        req_pc = 13'd8;
        cycle();
        flush = 1'b1; req_pc = 13'd9;
        #1 chk("flush_ready", 64'(req_ready), 64'd0);
        cycle();
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("flush_quiet%0d", i), 64'(rsp_valid), 64'd0);
            cycle();
        end

        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 13'd1;
        cycle();
        req_pc = 13'd2;
        cycle();
        req_valid = 1'b0;
        cycle();
        rst_n = 1'b0; ld_en = 1'b1; ld_addr = 13'd0; ld_data = 32'hBAD0_BAD0;
        #1;
        chk("rst_async_valid", 64'(rsp_valid), 64'd0);
        chk("rst_async_instr", 64'(rsp_instr), 64'd0);
        chk("rst_async_ready", 64'(req_ready), 64'd0);
        cycle();
        rst_n = 1'b1; ld_en = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 13'd0;
        cycle();
        req_valid = 1'b0;
        cycle();
        #1 chk("after_rst_A", 64'(rsp_instr), 64'(val(0)));
        cycle();

        idle();
        b_req_valid = 1'b1; b_req_pc = 15'h006;
        #1 chk("b_ready0", 64'(b_req_ready), 64'd1);
        cycle();
        b_req_pc = 15'h008;
        #1 chk("b_ready1", 64'(b_req_ready), 64'd1);
        cycle();
        b_req_valid = 1'b0;
        #1;
        chk("b_mis_valid", 64'(b_rsp_valid), 64'd1);
        chk("b_mis_err", 64'(b_rsp_err), 64'd1);
        chk("b_mis_instr", 64'(b_rsp_instr), 64'd0);
        chk("b_mis_pc", 64'(b_rsp_pc), 64'h006);
        cycle();
        #1;
        chk("b_ok_valid", 64'(b_rsp_valid), 64'd1);
        chk("b_ok_err", 64'(b_rsp_err), 64'd0);
        chk("b_ok_instr", 64'(b_rsp_instr), 64'(val(2)));
        chk("b_ok_pc", 64'(b_rsp_pc), 64'h008);
        cycle();
        #1 chk("b_drained", 64'(b_rsp_valid), 64'd0);
        cycle();

        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 4) != 0;
            rsp_ready = ($urandom % 4) != 0;
            req_pc    = 13'($urandom_range(0, 15));
            ld_en     = ($urandom % 16) == 0;
            ld_addr   = 13'($urandom_range(0, 15));
            ld_data   = $urandom;
            flush     = ($urandom % 25) == 0;
            cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 32: instruction width in bits, a multiple of 8.
- DEPTH_LOG2, 13: log2 of the word depth.
- BYTE_ADDR, 0: when 1, req_pc is a byte address.
- INIT_FILE, "": binary-text image loaded at time 0; empty means no preload.
REQ-002 PC_W SHALL be DEPTH_LOG2 + (BYTE_ADDR ? log2(DATA_W/8) : 0); OFF_W = PC_W - DEPTH_LOG2.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block accepts the request this cycle.
- req_pc  in  PC_W  fetch address.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_instr  out  DATA_W  fetched word.
- rsp_pc  out  PC_W  req_pc of this response.
- rsp_err  out  1  misaligned fetch.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  DEPTH_LOG2  load word address.
- ld_data  in  DATA_W  load word.
- flush  in  1  discard all outstanding fetches.

Function
REQ-004 Storage SHALL be 2^DEPTH_LOG2 words of DATA_W bits, preloaded from INIT_FILE when it is non-empty, and not cleared by reset.
REQ-005 Accept = req_valid & req_ready; pop = rsp_valid & rsp_ready.
REQ-006 A request accepted at posedge N SHALL read memory at that edge and SHALL be presented on rsp_* no earlier than the cycle after posedge N+1 (1-cycle latency when the output is empty).
REQ-007 Responses SHALL be delivered in acceptance order through a 2-entry output buffer.
REQ-008 Occupancy occ (buffered entries plus the in-flight read) SHALL never exceed 2.
REQ-009 req_ready SHALL equal !ld_en & !flush & (occ<2 | (occ==2 & pop)).
- Back-to-back accept every cycle SHALL be sustained while rsp_ready=1.
REQ-010 rsp_instr, rsp_pc and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-011 Word index SHALL be req_pc[PC_W-1:OFF_W].
- When BYTE_ADDR=1 and req_pc[OFF_W-1:0]!=0, the response SHALL carry rsp_err=1 and rsp_instr=0, in order, without a memory read.
REQ-012 When ld_en=1 at a posedge, mem[ld_addr] SHALL be written with ld_data.
- req_ready=0 during that cycle, so no read can collide with a load.
- A read already in flight SHALL return the pre-load value.
REQ-013 When flush=1 at a posedge, buffered entries and the in-flight read SHALL be discarded and occ SHALL become 0.
- rsp_valid SHALL be 0 from the next cycle.
- A concurrent req_valid is not accepted.
- A concurrent ld_en write SHALL still occur.
REQ-014 When pop and a read completion occur at the same edge, occ SHALL be unchanged and ordering preserved.
REQ-015 An out-of-range ld_addr or req_pc is impossible by construction; all index arithmetic SHALL wrap modulo 2^DEPTH_LOG2.

Reset
REQ-016 While rst_n=0, asynchronously:
- occ, buffer entries and the in-flight flag SHALL be 0.
- rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0.
- req_ready=0.
REQ-017 Assertion of rst_n mid-operation SHALL drop all outstanding fetches.
- Loads SHALL be ignored while rst_n=0.
- Memory contents SHALL be preserved.
REQ-018 After rst_n deasserts, req_ready SHALL be 1 at the first clock unless ld_en or flush is high.

Verification
REQ-019 Preload mem[0..3]=A,B,C,D, BYTE_ADDR=0, rsp_ready=1, req_pc=0,1,2,3 on consecutive cycles -> rsp_instr A,B,C,D on consecutive cycles, rsp_pc 0..3, req_ready constantly 1.
REQ-020 Backpressure test:
- Stimulus: rsp_ready=0, issue pc 0,1,2.
- Response: exactly two accepted; req_ready=0 thereafter; rsp_instr=A held stable.
- Then raise rsp_ready: A, B drain, and pc 2 is accepted in the same cycle as the first pop.
REQ-021 Load, then fetch:
- Stimulus: ld_en with ld_addr=5, ld_data=32'hDEADBEEF, then fetch pc 5.
- Response: req_ready=0 during the load; response 32'hDEADBEEF.
REQ-022 BYTE_ADDR=1, DATA_W=32, fetch pc 13'h006 then 13'h008 -> first response rsp_err=1, rsp_instr=0; second rsp_err=0, rsp_instr=mem[2].
REQ-023 Flush and reset:
- Flush with 2 outstanding -> rsp_valid=0 the next cycle, and no stale response ever appears.
- Pulse rst_n=0 mid-stream -> outputs 0 immediately; a later fetch of pc 0 returns A.
